// File: rtl/secuenciador_saltos.sv
// ----------------------------------------------------------------------------
// secuenciador_saltos
//
// Parametrised microprogram sequencer. Each enabled clock edge, the control
// store supplies an operation, a jump target and a condition selector. The
// sequencer then loads the next microprogram address into upc. The address
// can come from:
//   - sequential increment,
//   - a conditional or unconditional jump,
//   - call/return through a hardware LIFO return stack,
//   - hold,
//   - restart.
// All outputs are registered, so there is no combinational path from any
// input to any output.
//
// Parameters
//   ADDR_W      : width of upc and target
//   N_COND      : number of condition flags on cond_in
//   SEL_W       : width of cond_sel (2**SEL_W >= N_COND)
//   STACK_DEPTH : number of return-stack entries (>= 1)
//   RESET_ADDR  : address loaded on reset and on RESTART
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   advance enable; 0 = hold (op ignored)
//   op         in   operation code (NEXT/JCOND/JMP/CALL/RET/HOLD/RESTART)
//   cond_sel   in   index of the condition flag to test
//   cond_inv   in   invert the selected condition
//   cond_in    in   datapath status flags
//   target     in   jump / call destination
//   clear_err  in   synchronous clear of ovf/udf
//   upc        out  current microprogram address
//   jump_taken out  1 for the cycle after a non-sequential load
//   sp         out  return-stack occupancy
//   ovf        out  sticky: CALL attempted with the stack full
//   udf        out  sticky: RET attempted with the stack empty
// ----------------------------------------------------------------------------
module secuenciador_saltos #(
    parameter int                 ADDR_W      = 8,
    parameter int                 N_COND      = 4,
    parameter int                 SEL_W       = 2,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [SEL_W-1:0]                   cond_sel,
    input  logic                               cond_inv,
    input  logic [N_COND-1:0]                  cond_in,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               clear_err,
    output logic [ADDR_W-1:0]                  upc,
    output logic                               jump_taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               ovf,
    output logic                               udf
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    // The stack array is rounded up to a power of two, so that a push or pop
    // index can never address outside it. Only STACK_DEPTH entries are used.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NEXT    = 3'b000,
        OP_JCOND   = 3'b001,
        OP_JMP     = 3'b010,
        OP_CALL    = 3'b011,
        OP_RET     = 3'b100,
        OP_HOLD    = 3'b101,
        OP_RESTART = 3'b110,
        OP_RSVD    = 3'b111
    } op_e;

    op_e                 op_w;
    logic [ADDR_W-1:0]   upc_q, upc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                jt_q, jt_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [ADDR_W-1:0]   stack_q [2**IDX_W];

    logic [ADDR_W-1:0]   seq;
    logic [SP_W-1:0]     sp_dec;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    pop_idx;
    logic                push;
    logic                stack_full;
    logic                stack_empty;
    logic [2**SEL_W-1:0] cond_vec;
    logic                cond;

    assign op_w = op_e'(op);

    // Flags beyond N_COND are tied to 0. An out-of-range select therefore
    // reads 0 before inversion, without needing a range compare.
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_cond_vec
        if (i < N_COND) begin : g_flag
            assign cond_vec[i] = cond_in[i];
        end else begin : g_pad
            assign cond_vec[i] = 1'b0;
        end
    end

    assign cond        = cond_vec[cond_sel] ^ cond_inv;
    assign seq         = upc_q + ADDR_W'(1);   // wraps silently at all-ones
    assign sp_dec      = sp_q - SP_W'(1);
    assign push_idx    = sp_q[IDX_W-1:0];      // push writes entry[sp]
    assign pop_idx     = sp_dec[IDX_W-1:0];    // pop reads entry[sp-1]
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // NOTE: every signal driven here gets a default before the case statement.
    // Then no path leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        upc_d = upc_q;
        sp_d  = sp_q;
        jt_d  = 1'b0;
        push  = 1'b0;
        // Clear first, so that an error raised on the same edge overrides it.
        ovf_d = ovf_q & ~clear_err;
        udf_d = udf_q & ~clear_err;

        if (en) begin
            unique case (op_w)
                OP_NEXT, OP_RSVD: begin
                    upc_d = seq;
                end
                OP_JCOND: begin
                    upc_d = cond ? target : seq;
                    jt_d  = cond;
                end
                OP_JMP: begin
                    upc_d = target;
                    jt_d  = 1'b1;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        upc_d = seq;
                        ovf_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        sp_d  = sp_q + SP_W'(1);
                        upc_d = target;
                        jt_d  = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        upc_d = seq;
                        udf_d = 1'b1;
                    end else begin
                        sp_d  = sp_dec;
                        upc_d = stack_q[pop_idx];
                        jt_d  = 1'b1;
                    end
                end
                OP_HOLD: begin
                    upc_d = upc_q;
                end
                OP_RESTART: begin
                    upc_d = RESET_ADDR;
                    sp_d  = '0;
                end
                default: begin
                    upc_d = seq;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples the values from before the edge, whatever order the
    // blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q <= RESET_ADDR;
            sp_q  <= '0;
            jt_q  <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            jt_q  <= jt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // NOTE: the stack storage is deliberately not reset. An entry is always
    // written by a push before any pop can read it, since sp starts at 0.
    // Leaving it out of reset lets the array map onto plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= seq;
        end
    end

    assign upc        = upc_q;
    assign sp         = sp_q;
    assign jump_taken = jt_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule

// File: tb/tb_secuenciador_saltos.sv
// ----------------------------------------------------------------------------
// tb_secuenciador_saltos
//
// Bench for secuenciador_saltos, configured with N_COND=3 so that the
// out-of-range cond_sel case can be reached.
//
// The driver applies one operation per cycle on the falling edge. It then
// advances a behavioural model: an integer address, a queue used as the
// return stack, and two sticky bits. It pushes the expected post-edge state
// into a scoreboard queue. A monitor samples the DUT shortly after each
// rising edge, and pops and compares when an expectation is pending.
// ----------------------------------------------------------------------------
module tb_secuenciador_saltos;

    localparam int ADDR_W = 8;
    localparam int N_COND = 3;
    localparam int SEL_W  = 2;
    localparam int DEPTH  = 4;
    localparam int SP_W   = $clog2(DEPTH + 1);

    localparam int OP_NEXT    = 0;
    localparam int OP_JCOND   = 1;
    localparam int OP_JMP     = 2;
    localparam int OP_CALL    = 3;
    localparam int OP_RET     = 4;
    localparam int OP_HOLD    = 5;
    localparam int OP_RESTART = 6;
    localparam int OP_RSVD    = 7;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [2:0]        op;
    logic [SEL_W-1:0]  cond_sel;
    logic              cond_inv;
    logic [N_COND-1:0] cond_in;
    logic [ADDR_W-1:0] target;
    logic              clear_err;
    logic [ADDR_W-1:0] upc;
    logic              jump_taken;
    logic [SP_W-1:0]   sp;
    logic              ovf;
    logic              udf;

    secuenciador_saltos #(
        .ADDR_W      (ADDR_W),
        .N_COND      (N_COND),
        .SEL_W       (SEL_W),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .op         (op),
        .cond_sel   (cond_sel),
        .cond_inv   (cond_inv),
        .cond_in    (cond_in),
        .target     (target),
        .clear_err  (clear_err),
        .upc        (upc),
        .jump_taken (jump_taken),
        .sp         (sp),
        .ovf        (ovf),
        .udf        (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int upc;
        bit jt;
        int sp;
        bit ovf;
        bit udf;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_issued = 0;

    // Behavioural model state
    int   m_upc;
    int   m_stack[$];
    bit   m_ovf;
    bit   m_udf;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    function automatic void model_reset();
        m_upc = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    // One operation per cycle: drive on the falling edge, then predict the
    // state after the next rising edge.
    task automatic drive(input bit e, input int o, input int s, input bit inv,
                         input int ci, input int t, input bit clr);
        exp_t x;
        int   seq;
        bit   c;
        bit   jt;
        @(negedge clk);
        en        = e;
        op        = o[2:0];
        cond_sel  = s[SEL_W-1:0];
        cond_inv  = inv;
        cond_in   = ci[N_COND-1:0];
        target    = t[ADDR_W-1:0];
        clear_err = clr;

        seq = (m_upc + 1) % 256;
        c   = ((s < N_COND) ? ci[s] : 1'b0) ^ inv;
        jt  = 1'b0;
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (e) begin
            case (o)
                OP_JCOND: begin
                    if (c) begin m_upc = t % 256; jt = 1'b1; end
                    else m_upc = seq;
                end
                OP_JMP: begin
                    m_upc = t % 256;
                    jt = 1'b1;
                end
                OP_CALL: begin
                    if (m_stack.size() < DEPTH) begin
                        m_stack.push_back(seq);
                        m_upc = t % 256;
                        jt = 1'b1;
                    end else begin
                        m_upc = seq;
                        m_ovf = 1'b1;
                    end
                end
                OP_RET: begin
                    if (m_stack.size() > 0) begin
                        m_upc = m_stack.pop_back();
                        jt = 1'b1;
                    end else begin
                        m_upc = seq;
                        m_udf = 1'b1;
                    end
                end
                OP_HOLD: ;
                OP_RESTART: begin
                    m_upc = 0;
                    m_stack.delete();
                end
                default: m_upc = seq;   // NEXT and reserved
            endcase
        end
        x.upc = m_upc;
        x.jt  = jt;
        x.sp  = m_stack.size();
        x.ovf = m_ovf;
        x.udf = m_udf;
        x.idx = n_issued;
        n_issued++;
        exp_q.push_back(x);
    endtask

    // Monitor: compare whenever an expectation is pending.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check($sformatf("upc[op%0d]", x.idx), int'(upc), x.upc);
                check($sformatf("jump_taken[op%0d]", x.idx), int'(jump_taken), int'(x.jt));
                check($sformatf("sp[op%0d]", x.idx), int'(sp), x.sp);
                check($sformatf("ovf[op%0d]", x.idx), int'(ovf), int'(x.ovf));
                check($sformatf("udf[op%0d]", x.idx), int'(udf), int'(x.udf));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_upc"}, int'(upc), 0);
        check({tag, "_sp"}, int'(sp), 0);
        check({tag, "_jt"}, int'(jump_taken), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
        check({tag, "_udf"}, int'(udf), 0);
    endtask

    // Watchdog: a run that stops making progress still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        op        = 3'b000;
        cond_sel  = '0;
        cond_inv  = 1'b0;
        cond_in   = '0;
        target    = '0;
        clear_err = 1'b0;
        model_reset();
        #12;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential advance: 0 -> 1 -> 2 -> 3
        repeat (3) drive(1, OP_NEXT, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run, between clock edges
        wait_drain();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // JCOND on flag 2, plain and inverted
        drive(1, OP_JMP,   0, 0, 0,       8'h10, 0);
        drive(1, OP_JCOND, 2, 0, 3'b100,  8'h80, 0);   // taken -> 0x80
        drive(1, OP_JMP,   0, 0, 0,       8'h10, 0);
        drive(1, OP_JCOND, 2, 1, 3'b100,  8'h80, 0);   // not taken -> 0x11

        // Out-of-range select reads 0 before inversion
        drive(1, OP_JCOND, 3, 1, 3'b111,  8'h44, 0);   // taken
        drive(1, OP_JCOND, 3, 0, 3'b111,  8'h66, 0);   // not taken

        // Nested calls, overflow, returns, underflow
        drive(1, OP_JMP,  0, 0, 0, 8'h05, 0);
        drive(1, OP_CALL, 0, 0, 0, 8'h20, 0);
        drive(1, OP_CALL, 0, 0, 0, 8'h30, 0);
        drive(1, OP_CALL, 0, 0, 0, 8'h40, 0);
        drive(1, OP_CALL, 0, 0, 0, 8'h50, 0);
        drive(1, OP_CALL, 0, 0, 0, 8'h99, 0);          // overflow -> 0x51
        repeat (4) drive(1, OP_RET, 0, 0, 0, 0, 0);    // 41, 31, 21, 06
        drive(1, OP_RET, 0, 0, 0, 0, 0);               // underflow -> 0x07

        // Overflow and clear on the same edge: the set wins for ovf
        repeat (4) drive(1, OP_CALL, 0, 0, 0, 8'h60, 0);
        drive(1, OP_CALL, 0, 0, 0, 8'h70, 1);
        drive(1, OP_NEXT, 0, 0, 0, 0, 1);              // clear alone
        drive(1, OP_RET,  0, 0, 0, 0, 0);              // sp 4 -> 3
        drive(1, OP_RESTART, 0, 0, 0, 8'h33, 0);

        // Wrap, hold, disabled jump, reserved opcode, jump to seq
        drive(1, OP_JMP,  0, 0, 0, 8'hFF, 0);
        drive(1, OP_NEXT, 0, 0, 0, 0, 0);              // 0xFF -> 0x00
        repeat (2) drive(1, OP_HOLD, 0, 0, 0, 0, 0);
        drive(0, OP_JMP,  0, 0, 0, 8'hAB, 0);
        drive(0, OP_CALL, 0, 0, 0, 8'hAB, 0);
        drive(1, OP_RSVD, 0, 0, 0, 8'hAB, 0);
        drive(1, OP_JMP,  0, 0, 0, 8'h02, 0);          // target == seq

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 7) == 0));
        end

        wait_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
